// File: rtl/dwrr_sched_pkg.sv
// dwrr_sched_pkg: state encoding and parameter sanity helper shared by the scheduler
package dwrr_sched_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    function automatic bit deficit_width_ok(input int dw, input int lw, input int ww);
        return dw >= ((lw > ww ? lw : ww) + 1);
    endfunction

endpackage

// File: rtl/dwrr_ffs.sv
// dwrr_ffs: lowest-index find-first-set over N request bits
module dwrr_ffs #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end

endmodule

// File: rtl/dwrr_sched.sv
// dwrr_sched: deficit-weighted round-robin scheduler with per-queue strict-priority override
module dwrr_sched
    import dwrr_sched_pkg::*;
#(
    parameter int QUEUE_NUM_WIDTH = 2,
    parameter int QUEUE_NUM       = 2 ** QUEUE_NUM_WIDTH,
    parameter int WEIGHT_WIDTH    = 7,
    parameter int LEN_WIDTH       = 11,
    parameter int DEFICIT_WIDTH   = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [QUEUE_NUM*WEIGHT_WIDTH-1:0] sch_weight,
    input  logic [QUEUE_NUM*LEN_WIDTH-1:0]    sch_len,
    input  logic [QUEUE_NUM-1:0]              sch_rdy,
    input  logic [QUEUE_NUM-1:0]              sch_sp_mask,
    input  logic                              sch_en,
    output logic                              sch_busy,
    output logic                              sch_winner_vld,
    output logic [QUEUE_NUM_WIDTH-1:0]        sch_winner,
    output logic                              sch_none
);

    if (!deficit_width_ok(DEFICIT_WIDTH, LEN_WIDTH, WEIGHT_WIDTH)) begin : g_width_check
        $error("dwrr_sched: DEFICIT_WIDTH too narrow for LEN_WIDTH/WEIGHT_WIDTH");
    end

    logic [0:0]                 state;
    logic [QUEUE_NUM_WIDTH-1:0] ptr;
    logic [QUEUE_NUM_WIDTH-1:0] sp_idx;
    logic [DEFICIT_WIDTH-1:0]   deficit [QUEUE_NUM];
    logic [QUEUE_NUM-1:0]       sp_vec;
    logic [QUEUE_NUM-1:0]       dwrr_vec;
    logic                       sp_any;
    logic                       dwrr_any;
    logic [DEFICIT_WIDTH-1:0]   cur_def;
    logic [DEFICIT_WIDTH-1:0]   cur_w;
    logic [DEFICIT_WIDTH-1:0]   cur_len;
    logic [DEFICIT_WIDTH-1:0]   sat_sum;
    logic [DEFICIT_WIDTH:0]     sum;

    assign sp_vec = sch_rdy & sch_sp_mask;

    for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_elig
        assign dwrr_vec[q] = sch_rdy[q] & ~sch_sp_mask[q] & (|sch_weight[q*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end

    dwrr_ffs #(.N(QUEUE_NUM), .W(QUEUE_NUM_WIDTH)) u_sp_ffs (
        .req (sp_vec),
        .any (sp_any),
        .idx (sp_idx)
    );

    assign dwrr_any = |dwrr_vec;
    assign cur_def  = deficit[ptr];
    assign cur_w    = DEFICIT_WIDTH'(sch_weight[ptr*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    assign cur_len  = DEFICIT_WIDTH'(sch_len[ptr*LEN_WIDTH +: LEN_WIDTH]);
    assign sum      = {1'b0, cur_def} + {1'b0, cur_w};
    assign sat_sum  = sum[DEFICIT_WIDTH] ? '1 : sum[DEFICIT_WIDTH-1:0];
    assign sch_busy = state == SCAN;

    // Grant on a DWRR hit leaves ptr in place so the queue can spend leftover deficit next request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            sch_winner_vld <= 1'b0;
            sch_winner     <= '0;
            sch_none       <= 1'b0;
            for (int i = 0; i < QUEUE_NUM; i++) deficit[i] <= '0;
        end else begin
            sch_winner_vld <= 1'b0;
            sch_none       <= 1'b0;
            if (state == IDLE) begin
                if (sch_en) state <= SCAN;
            end else if (sp_any) begin
                state          <= IDLE;
                sch_winner_vld <= 1'b1;
                sch_winner     <= sp_idx;
            end else if (!dwrr_any) begin
                state        <= IDLE;
                sch_none     <= 1'b1;
                deficit[ptr] <= '0;
            end else if (!dwrr_vec[ptr]) begin
                deficit[ptr] <= '0;
                ptr          <= ptr + 1'b1;
            end else if (cur_def >= cur_len) begin
                state          <= IDLE;
                sch_winner_vld <= 1'b1;
                sch_winner     <= ptr;
                deficit[ptr]   <= cur_def - cur_len;
            end else begin
                deficit[ptr] <= sat_sum;
                ptr          <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dwrr_sched.sv
// tb_dwrr_sched: scoreboard bench for the deficit-weighted round-robin scheduler
module tb_dwrr_sched;

    localparam int QW = 2;
    localparam int QN = 4;
    localparam int WW = 7;
    localparam int LW = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [QN*WW-1:0] sch_weight = '0;
    logic [QN*LW-1:0] sch_len = '0;
    logic [QN-1:0]    sch_rdy = '0;
    logic [QN-1:0]    sch_sp_mask = '0;
    logic             sch_en = 1'b0;
    logic             sch_busy;
    logic             sch_winner_vld;
    logic [QW-1:0]    sch_winner;
    logic             sch_none;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dwrr_sched dut (
        .clk            (clk),
        .rst            (rst),
        .sch_weight     (sch_weight),
        .sch_len        (sch_len),
        .sch_rdy        (sch_rdy),
        .sch_sp_mask    (sch_sp_mask),
        .sch_en         (sch_en),
        .sch_busy       (sch_busy),
        .sch_winner_vld (sch_winner_vld),
        .sch_winner     (sch_winner),
        .sch_none       (sch_none)
    );

    always #5 clk = ~clk;

    function automatic int observed();
        return sch_none ? -1 : (sch_winner_vld ? int'(sch_winner) : -2);
    endfunction

    task automatic set_q(input int q, input int w, input int l);
        sch_weight[q*WW +: WW] = WW'(w);
        sch_len[q*LW +: LW]    = LW'(l);
    endtask

    task automatic set_all(input int w, input int l);
        for (int q = 0; q < QN; q++) set_q(q, w, l);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        sch_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Raises sch_en and waits for vld/none; pulse drops sch_en after the first edge
    task automatic await_decision(input int budget, input bit pulse, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        sch_en = 1'b1;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pulse) sch_en = 1'b0;
            got = sch_winner_vld || sch_none;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sch_busy, sch_winner_vld, sch_winner, sch_none} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b vld=%b winner=%0d none=%b, want all 0", sch_busy, sch_winner_vld, sch_winner, sch_none);
        end
        checks++;
        if (dut.ptr !== '0 || dut.deficit[0] !== '0 || dut.deficit[3] !== '0) begin
            errors++;
            $display("FAIL reset_state: ptr=%0d def0=%0d def3=%0d, want 0", dut.ptr, dut.deficit[0], dut.deficit[3]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_equal_rr();
        int cyc, exp;
        bit got;
        reset_dut();
        set_all(2, 2);
        sch_rdy = 4'hF;
        sch_sp_mask = '0;
        exp_q.push_back(0);
        await_decision(20, 1'b0, cyc, got);
        checks++;
        if (!got || cyc != 6) begin
            errors++;
            $display("FAIL rr_first_latency: got %0d cycles (seen=%b), want 6", cyc, got);
        end
        exp = exp_q.pop_front();
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL rr_first_winner: got %0d, want %0d", observed(), exp);
        end
        for (int j = 1; j <= 8; j++) begin
            exp_q.push_back(j % 4);
            await_decision(20, 1'b0, cyc, got);
            if (j == 8) sch_en = 1'b0;
            exp = exp_q.pop_front();
            checks++;
            if (!got || cyc != 3 || observed() !== exp) begin
                errors++;
                $display("FAIL rr_rotation[%0d]: winner %0d after %0d cycles, want %0d after 3", j, observed(), cyc, exp);
            end
        end
    endtask

    task automatic test_weighted_share();
        int cyc, exp, cnt0, cnt1;
        bit got;
        int seq[10] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0};
        reset_dut();
        set_all(2, 2);
        set_q(0, 4, 2);
        sch_rdy = 4'hF;
        exp_q.push_back(0);
        await_decision(20, 1'b0, cyc, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || observed() !== exp) begin
            errors++;
            $display("FAIL wrr_first: winner %0d, want %0d", observed(), exp);
        end
        cnt0 = 0;
        cnt1 = 0;
        for (int j = 0; j < 10; j++) begin
            exp_q.push_back(seq[j]);
            await_decision(20, 1'b0, cyc, got);
            if (j == 9) sch_en = 1'b0;
            if (got && sch_winner == 0) cnt0++;
            if (got && sch_winner == 1) cnt1++;
            exp = exp_q.pop_front();
            checks++;
            if (!got || observed() !== exp) begin
                errors++;
                $display("FAIL wrr_seq[%0d]: winner %0d, want %0d", j, observed(), exp);
            end
        end
        checks++;
        if (cnt0 != 2 * cnt1) begin
            errors++;
            $display("FAIL wrr_share: q0 %0d grants, q1 %0d grants, want 2:1", cnt0, cnt1);
        end
    endtask

    task automatic test_strict_priority();
        int cyc, exp;
        bit got;
        reset_dut();
        set_all(2, 2);
        sch_rdy = 4'hF;
        sch_sp_mask = 4'b1000;
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back(3);
            await_decision(10, 1'b1, cyc, got);
            exp = exp_q.pop_front();
            checks++;
            if (!got || cyc != 2 || observed() !== exp) begin
                errors++;
                $display("FAIL sp_grant[%0d]: winner %0d after %0d edges, want %0d after 2", j, observed(), cyc, exp);
            end
        end
        for (int i = 0; i < QN; i++) begin
            checks++;
            if (dut.deficit[i] !== '0) begin
                errors++;
                $display("FAIL sp_deficit[%0d]: %0d, want 0", i, dut.deficit[i]);
            end
        end
    endtask

    task automatic test_no_eligible();
        int cyc, exp;
        bit got;
        reset_dut();
        set_all(2, 2);
        sch_rdy = 4'b0100;
        sch_sp_mask = 4'b0100;
        exp_q.push_back(2);
        await_decision(10, 1'b1, cyc, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || observed() !== exp) begin
            errors++;
            $display("FAIL none_setup: winner %0d, want %0d", observed(), exp);
        end
        sch_sp_mask = '0;
        for (int j = 0; j < 2; j++) begin
            sch_rdy = (j == 0) ? 4'b0000 : 4'b0010;
            set_q(1, (j == 0) ? 2 : 0, 2);
            exp_q.push_back(-1);
            sch_en = 1'b1;
            @(negedge clk);
            sch_en = 1'b0;
            checks++;
            if (sch_busy !== 1'b1 || sch_none !== 1'b0) begin
                errors++;
                $display("FAIL none_busy[%0d]: busy=%b none=%b, want 1 0", j, sch_busy, sch_none);
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (observed() !== exp || sch_winner_vld !== 1'b0 || sch_busy !== 1'b0 || sch_winner !== 2'd2) begin
                errors++;
                $display("FAIL none_pulse[%0d]: none=%b vld=%b busy=%b winner=%0d, want 1 0 0 2", j, sch_none, sch_winner_vld, sch_busy, sch_winner);
            end
            @(negedge clk);
            checks++;
            if (sch_none !== 1'b0 || sch_winner_vld !== 1'b0) begin
                errors++;
                $display("FAIL none_single[%0d]: none=%b vld=%b, want 0 0", j, sch_none, sch_winner_vld);
            end
        end
    endtask

    task automatic test_long_packet();
        int cyc, exp;
        bit got;
        reset_dut();
        set_all(2, 2);
        set_q(0, 127, 2047);
        sch_rdy = 4'b0001;
        sch_sp_mask = '0;
        exp_q.push_back(0);
        await_decision(200, 1'b1, cyc, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || cyc != 70 || observed() !== exp) begin
            errors++;
            $display("FAIL long_grant: winner %0d after %0d edges, want %0d after 70", observed(), cyc, exp);
        end
        checks++;
        if (dut.deficit[0] !== 12'd112) begin
            errors++;
            $display("FAIL long_deficit: %0d, want 112", dut.deficit[0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, exp;
        bit got;
        reset_dut();
        set_all(2, 2);
        sch_rdy = 4'hF;
        sch_sp_mask = 4'b1000;
        exp_q.push_back(3);
        await_decision(10, 1'b1, cyc, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || observed() !== exp) begin
            errors++;
            $display("FAIL mid_setup: winner %0d, want %0d", observed(), exp);
        end
        sch_sp_mask = '0;
        sch_en = 1'b1;
        exp_q.push_back(0);
        @(negedge clk);
        @(negedge clk);
        sch_en = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({sch_busy, sch_winner_vld, sch_winner, sch_none} !== '0 || dut.ptr !== '0 || dut.deficit[0] !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b vld=%b winner=%0d none=%b ptr=%0d def0=%0d, want all 0", sch_busy, sch_winner_vld, sch_winner, sch_none, dut.ptr, dut.deficit[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(0);
        await_decision(20, 1'b0, cyc, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || cyc != 6 || observed() !== exp) begin
            errors++;
            $display("FAIL mid_replay_first: winner %0d after %0d cycles, want %0d after 6", observed(), cyc, exp);
        end
        exp_q.push_back(1);
        await_decision(20, 1'b0, cyc, got);
        sch_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (!got || cyc != 3 || observed() !== exp) begin
            errors++;
            $display("FAIL mid_replay_next: winner %0d after %0d cycles, want %0d after 3", observed(), cyc, exp);
        end
    endtask

    initial begin
        test_reset();
        test_equal_rr();
        test_weighted_share();
        test_strict_priority();
        test_no_eligible();
        test_long_packet();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwrr_sched.md
# dwrr_sched

Parametrised deficit-weighted round-robin scheduler with optional strict-priority queues. It is the successor to the weight-based queue scheduler and adds per-queue packet-length accounting, a per-queue strict-priority mode, saturating deficit counters and an explicit no-winner indication. It sits between the per-queue packet FIFOs, which supply ready flags and head-of-line lengths, and the dequeue/egress logic, which consumes one winner per request.

## Interface
Parameters:
- QUEUE_NUM_WIDTH, 2, log2 of queue count
- QUEUE_NUM, 2**QUEUE_NUM_WIDTH, number of queues
- WEIGHT_WIDTH, 7, per-queue quantum width
- LEN_WIDTH, 11, head-packet length width
- DEFICIT_WIDTH, 12, deficit counter width; must be ≥ max(LEN_WIDTH, WEIGHT_WIDTH)+1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sch_weight  in  QUEUE_NUM*WEIGHT_WIDTH  quantum of queue i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- sch_len  in  QUEUE_NUM*LEN_WIDTH  head packet length of queue i, same packing
- sch_rdy  in  QUEUE_NUM  queue i has a packet
- sch_sp_mask  in  QUEUE_NUM  queue i is strict-priority
- sch_en  in  1  decision request; sampled only in IDLE
- sch_busy  out  1  high while in SCAN
- sch_winner_vld  out  1  one-cycle pulse, winner valid
- sch_winner  out  QUEUE_NUM_WIDTH  winning queue index, held until next winner
- sch_none  out  1  one-cycle pulse, request ended with no eligible queue

## Operation
- States: IDLE, SCAN. IDLE → SCAN when sch_en=1. SCAN → IDLE on grant or abort.
- Live inputs are evaluated each SCAN cycle. Upstream keeps sch_len stable for a ready queue until a decision is made.
- A queue is SP-eligible when sch_rdy & sch_sp_mask is set.
- A queue is DWRR-eligible when sch_rdy & ~sch_sp_mask & (weight≠0) is set.
- Each SCAN cycle, checked in priority order:
  1. Any SP-eligible queue: the lowest-index SP-eligible queue wins. Deficits and ptr are unchanged.
  2. No eligible queue of either kind: abort, pulse sch_none, deficit[ptr] cleared to 0.
  3. Queue ptr not DWRR-eligible: deficit[ptr] cleared to 0, ptr incremented (wraps at QUEUE_NUM-1 → 0).
  4. deficit[ptr] ≥ len[ptr]: grant ptr, deficit[ptr] -= len[ptr], ptr unchanged so the queue keeps its turn.
  5. Otherwise: deficit[ptr] += weight[ptr], saturating at 2^DEFICIT_WIDTH-1, and ptr is incremented.
- All arithmetic is unsigned. Weight and length are zero-extended to DEFICIT_WIDTH.
- SP queues and weight-0 queues never accumulate deficit.
- A grant updates sch_winner and pulses sch_winner_vld on the next cycle.

## Timing
- Reset values: state IDLE, ptr 0, all deficits 0, sch_busy 0, sch_winner_vld 0, sch_winner 0, sch_none 0.
- Reset asserted mid-SCAN: all of the above take effect immediately, and any pending decision is lost.
- sch_en sampled at edge k → sch_busy=1 from k. Grant or abort is evaluated in the SCAN cycle ending at edge k+n (n≥1). sch_winner_vld or sch_none is high for the cycle after edge k+n, and sch_busy is 0 in that cycle.
- Minimum latency is 2 edges (SP win, or DWRR hit on the first visit).
- DWRR latency is unbounded by design; it depends on len/weight.
- sch_en high in the cycle where vld or none is high is accepted, giving a maximum of one decision per 2 cycles.
- sch_en during SCAN is ignored.
- Exactly one of sch_winner_vld or sch_none pulses per accepted request.

## Structure
- Shared package dwrr_sched_pkg holds:
  - state encoding localparams (IDLE, SCAN);
  - a width-check constant function for DEFICIT_WIDTH.
- Sub-module dwrr_ffs: parametrised lowest-index find-first-set over QUEUE_NUM bits, used for SP selection and the any-eligible checks.
- Deficit array, ptr, and FSM live in the top level.

## Test plan
- All weights 2, all len 2, all ready, no SP, sch_en held high:
  - first winner q0 after 5 SCAN cycles;
  - then q1, q2, q3, q0 repeating, each 3 cycles apart.
- Weights 4,2,2,2, len 2, all ready: after the first q0 grant, 10 consecutive winners are q0,q1,q2,q3,q0,q0,q1,q2,q3,q0; q0 gets 2× the share of each other queue.
- sch_sp_mask=4'b1000, all ready:
  - every winner is q3, vld 2 edges after sch_en;
  - the DWRR deficits probed remain 0.
- sch_rdy=0 (or only weight-0 queues ready), sch_en pulse:
  - sch_busy high 1 cycle, then sch_none pulses once;
  - sch_winner_vld stays 0 and sch_winner is unchanged.
- q0 only ready, weight 127, len 2047: grant after 17 q0 visits, with deficit[q0] = 2159−2047 = 112 after the grant.
- rst pulsed while sch_busy=1:
  - outputs 0 in the same cycle;
  - the next request with weights 2, len 2 reproduces the first scenario from q0.
